// File: rtl/freq_meter_pkg.sv
// Shared constants and state encoding for the frequency meter and its edge detector.
package freq_meter_pkg;

    localparam int DEF_GATE_CYCLES = 50_000_000;
    localparam int DEF_GATE_W      = 26;
    localparam int DEF_CNT_W       = 26;
    localparam int SYNC_STAGES     = 3;

    // The arm counter saturates here; edges are masked until then.
    localparam logic [1:0] ARM_DONE = 2'(SYNC_STAGES);

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchroniser with a rising-edge pulse.
// The arm mask suppresses the false edge that a static-high input would produce after reset.
module sync_edge_det
    import freq_meter_pkg::*;
(
    input  logic iCLK_50,
    input  logic iRST,
    input  logic iSIG,
    output logic oEDGE
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_arm;

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            r_sync <= '0;
            r_arm  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], iSIG};
            if (r_arm != ARM_DONE)
                r_arm <= r_arm + 2'd1;
        end
    end

    assign oEDGE = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1] & (r_arm == ARM_DONE);

endmodule

// File: rtl/freq_meter.sv
// Counts synchronised rising edges of iSIG over back-to-back GATE_CYCLES windows
// and publishes each completed window's count with a one-cycle oVALID pulse.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             iCLK_50,
    input  logic             iRST,
    input  logic             iSIG,
    input  logic             iEN,
    output logic [CNT_W-1:0] oFREQ,
    output logic             oVALID,
    output logic             oOVF,
    output logic             oGATE
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t r_state, w_state_nxt;

    logic              w_edge;
    logic              w_last;
    logic              w_cnt_full;
    logic [CNT_W-1:0]  w_edge_nxt;
    logic              w_sat_nxt;

    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_sat;
    logic [CNT_W-1:0]  r_freq;
    logic              r_valid;
    logic              r_ovf;

    sync_edge_det u_sync (
        .iCLK_50 (iCLK_50),
        .iRST    (iRST),
        .iSIG    (iSIG),
        .oEDGE   (w_edge)
    );

    always_ff @(posedge iCLK_50) begin
        if (iRST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Dropping iEN on the terminal cycle still leaves GATE; the datapath
    // completes that window regardless of the state transition.
    always_comb begin
        w_state_nxt = r_state;
        w_last      = (r_state == GATE) && (r_gate_cnt == GATE_LAST);
        w_cnt_full  = (r_edge_cnt == CNT_MAX);
        w_edge_nxt  = (w_edge && !w_cnt_full) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
        w_sat_nxt   = r_sat | (w_edge & w_cnt_full);
        case (r_state)
            IDLE:    if (iEN)  w_state_nxt = GATE;
            GATE:    if (!iEN) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            r_freq     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_last) begin
                // Terminal-cycle edge belongs to the closing window.
                r_freq     <= w_edge_nxt;
                r_ovf      <= w_sat_nxt;
                r_valid    <= 1'b1;
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_sat      <= 1'b0;
            end else if (r_state == GATE && iEN) begin
                r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                r_edge_cnt <= w_edge_nxt;
                r_sat      <= w_sat_nxt;
            end else begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_sat      <= 1'b0;
            end
        end
    end

    assign oFREQ  = r_freq;
    assign oVALID = r_valid;
    assign oOVF   = r_ovf;
    assign oGATE  = (r_state == GATE);

endmodule
